// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch conditions
// and processor status.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_XOR = 2'd3;

   localparam logic [3:0] C_ALWAYS = 4'd0;
   localparam logic [3:0] C_LE     = 4'd1;
   localparam logic [3:0] C_L      = 4'd2;
   localparam logic [3:0] C_E      = 4'd3;
   localparam logic [3:0] C_NE     = 4'd4;
   localparam logic [3:0] C_GE     = 4'd5;
   localparam logic [3:0] C_G      = 4'd6;

   typedef enum logic [1:0] {
      STAT_AOK = 2'd0,
      STAT_HLT = 2'd1,
      STAT_ADR = 2'd2,
      STAT_INS = 2'd3
   } stat_e;

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute bundle: decoded fields in, ALU result, condition and
// architectural state out.
interface execute_if #(parameter int DATA_W = 64);
   logic [3:0]        icode;
   logic [3:0]        ifun;
   logic [DATA_W-1:0] valA;
   logic [DATA_W-1:0] valB;
   logic [DATA_W-1:0] valC;
   logic              imem_error;
   logic              instr_valid;
   logic [DATA_W-1:0] valE;
   logic              cnd;
   logic [2:0]        cc;
   logic [1:0]        stat;

   modport master (
      output icode, ifun, valA, valB, valC, imem_error, instr_valid,
      input  valE, cnd, cc, stat
   );

   modport slave (
      input  icode, ifun, valA, valB, valC, imem_error, instr_valid,
      output valE, cnd, cc, stat
   );
endinterface

// File: rtl/alu.sv
// Combinational Y86-64 ALU: valE = aluB op aluA, plus the ZF/SF/OF flags
// that result would produce.
module alu
   import y86_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic signed [DATA_W-1:0] aluA,
   input  logic signed [DATA_W-1:0] aluB,
   input  logic        [1:0]        alufun,
   output logic signed [DATA_W-1:0] valE,
   output logic                     zf,
   output logic                     sf,
   output logic                     of
);

   always_comb begin
      valE = '0;
      of   = 1'b0;
      case (alufun)
         ALU_ADD: begin
            valE = aluB + aluA;
            of   = (aluA[DATA_W-1] == aluB[DATA_W-1]) &&
                   (valE[DATA_W-1] != aluA[DATA_W-1]);
         end
         ALU_SUB: begin
            valE = aluB - aluA;
            of   = (aluA[DATA_W-1] != aluB[DATA_W-1]) &&
                   (valE[DATA_W-1] != aluB[DATA_W-1]);
         end
         ALU_AND: valE = aluB & aluA;
         ALU_XOR: valE = aluB ^ aluA;
         default: valE = '0;
      endcase
      zf = (valE == '0);
      sf = valE[DATA_W-1];
   end

endmodule

// File: rtl/execute.sv
// Y86-64 sequential execute stage: operand/function selection, condition
// evaluation, and the CC and status registers that freeze outside AOK.
module execute
   import y86_pkg::*;
#(
   parameter int         DATA_W   = 64,
   parameter logic [2:0] CC_RESET = 3'b100
) (
   input  logic      clk,
   input  logic      rst_n,
   execute_if.slave  ex
);

   logic signed [DATA_W-1:0] alu_a;
   logic signed [DATA_W-1:0] alu_b;
   logic        [1:0]        alu_fun;
   logic signed [DATA_W-1:0] alu_e;
   logic                     alu_zf, alu_sf, alu_of;
   logic                     illegal_op;
   logic                     illegal_cond;
   logic                     cc_we;
   logic        [2:0]        cc_q;
   stat_e                    stat_q, stat_nxt, next_stat;

   function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] flags);
      logic zf, sf, of;
      {zf, sf, of} = flags;
      case (fn)
         C_ALWAYS: cond_eval = 1'b1;
         C_LE:     cond_eval = (sf ^ of) | zf;
         C_L:      cond_eval = sf ^ of;
         C_E:      cond_eval = zf;
         C_NE:     cond_eval = !zf;
         C_GE:     cond_eval = !(sf ^ of);
         C_G:      cond_eval = !(sf ^ of) && !zf;
         default:  cond_eval = 1'b0;
      endcase
   endfunction

   always_comb begin
      alu_a = '0;
      alu_b = '0;
      case (ex.icode)
         I_RRMOVQ, I_OPQ:             alu_a = ex.valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = ex.valC;
         I_CALL, I_PUSHQ:             alu_a = -DATA_W'(8);
         I_RET, I_POPQ:               alu_a = DATA_W'(8);
         default:                     alu_a = '0;
      endcase
      case (ex.icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = ex.valB;
         default:                                                  alu_b = '0;
      endcase
   end

   assign alu_fun = (ex.icode == I_OPQ) ? ex.ifun[1:0] : ALU_ADD;

   alu #(.DATA_W(DATA_W)) u_alu (
      .aluA   (alu_a),
      .aluB   (alu_b),
      .alufun (alu_fun),
      .valE   (alu_e),
      .zf     (alu_zf),
      .sf     (alu_sf),
      .of     (alu_of)
   );

   assign illegal_op   = (ex.icode == I_OPQ) && (ex.ifun > 4'd3);
   assign illegal_cond = ((ex.icode == I_RRMOVQ) || (ex.icode == I_JXX)) && (ex.ifun > 4'd6);

   assign ex.valE = illegal_op ? '0 : alu_e;
   // Conditions read the flags as they stood before this edge.
   assign ex.cnd  = ((ex.icode == I_RRMOVQ) || (ex.icode == I_JXX)) ? cond_eval(ex.ifun, cc_q) : 1'b0;

   always_comb begin
      if (ex.imem_error)                          next_stat = STAT_ADR;
      else if (!ex.instr_valid || illegal_op ||
               illegal_cond)                      next_stat = STAT_INS;
      else if (ex.icode == I_HALT)                next_stat = STAT_HLT;
      else                                        next_stat = STAT_AOK;
   end

   always_comb begin
      stat_nxt = stat_q;
      if (stat_q == STAT_AOK) stat_nxt = next_stat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stat_q <= STAT_AOK;
      else        stat_q <= stat_nxt;
   end

   assign cc_we = (stat_q == STAT_AOK) && (next_stat == STAT_AOK) && (ex.icode == I_OPQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     cc_q <= CC_RESET;
      else if (cc_we) cc_q <= {alu_zf, alu_sf, alu_of};
   end

   assign ex.cc   = cc_q;
   assign ex.stat = stat_q;

endmodule

// File: tb/tb_execute.sv
// Randomized and directed checks of the execute stage against a
// behavioural model of the Y86-64 execute rules.
module tb_execute;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [2:0]  m_cc;
   logic [1:0]  m_stat;
   logic [63:0] e_valE, o_valE;
   logic        e_cnd, o_cnd;
   logic [2:0]  o_cc;
   logic [1:0]  o_stat;

   execute_if #(.DATA_W(64)) ifc ();

   execute #(.DATA_W(64), .CC_RESET(3'b100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ex    (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_comb(
      input  logic [3:0]  ic, fn,
      input  logic [63:0] a, b, c,
      input  logic [2:0]  flags_now,
      output logic [63:0] ve,
      output logic        cnd_o,
      output logic [2:0]  flags_new,
      output logic        bad_fn);
      logic [63:0]       opa, opb;
      logic signed [65:0] wide;
      logic              ovf, zf, sf, of_;
      opa = 64'd0;
      opb = 64'd0;
      ovf = 1'b0;
      wide = '0;
      if (ic == 4'h2 || ic == 4'h6)                    opa = a;
      else if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) opa = c;
      else if (ic == 4'h8 || ic == 4'hA)               opa = 64'hFFFF_FFFF_FFFF_FFF8;
      else if (ic == 4'h9 || ic == 4'hB)               opa = 64'd8;
      if (ic >= 4'h4 && ic <= 4'hB && ic != 4'h7)     opb = b;
      bad_fn = (ic == 4'h6 && fn > 4'd3) || ((ic == 4'h2 || ic == 4'h7) && fn > 4'd6);
      if (ic == 4'h6 && fn == 4'd0) begin
         wide = $signed({{2{opb[63]}}, opb}) + $signed({{2{opa[63]}}, opa});
         ve   = wide[63:0];
         ovf  = (wide > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -66'sh0_8000_0000_0000_0000);
      end else if (ic == 4'h6 && fn == 4'd1) begin
         wide = $signed({{2{opb[63]}}, opb}) - $signed({{2{opa[63]}}, opa});
         ve   = wide[63:0];
         ovf  = (wide > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -66'sh0_8000_0000_0000_0000);
      end else if (ic == 4'h6 && fn == 4'd2) ve = opb & opa;
      else if (ic == 4'h6 && fn == 4'd3)     ve = opb ^ opa;
      else if (ic == 4'h6)                   ve = 64'd0;
      else                                   ve = opb + opa;
      flags_new = {ve == 64'd0, ve[63], ovf};
      {zf, sf, of_} = flags_now;
      cnd_o = 1'b0;
      if ((ic == 4'h2 || ic == 4'h7) && !bad_fn) begin
         case (fn)
            4'd0: cnd_o = 1'b1;
            4'd1: cnd_o = (sf != of_) || zf;
            4'd2: cnd_o = (sf != of_);
            4'd3: cnd_o = zf;
            4'd4: cnd_o = !zf;
            4'd5: cnd_o = (sf == of_);
            default: cnd_o = (sf == of_) && !zf;
         endcase
      end
   endfunction

   task automatic cycle(input logic [3:0] ic, fn, input logic [63:0] a, b, c,
                        input logic err, vld);
      logic [2:0] flags;
      logic       bad;
      logic [1:0] ns;
      ifc.icode = ic; ifc.ifun = fn;
      ifc.valA = a; ifc.valB = b; ifc.valC = c;
      ifc.imem_error = err; ifc.instr_valid = vld;
      model_comb(ic, fn, a, b, c, m_cc, e_valE, e_cnd, flags, bad);
      ns = err ? 2'd2 : (!vld || bad) ? 2'd3 : (ic == 4'h0) ? 2'd1 : 2'd0;
      #1;
      o_valE = ifc.valE;
      o_cnd  = ifc.cnd;
      if (m_stat == 2'd0) begin
         if (ns == 2'd0 && ic == 4'h6) m_cc = flags;
         m_stat = ns;
      end
      @(posedge clk);
      #1;
      o_cc   = ifc.cc;
      o_stat = ifc.stat;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      @(negedge clk);
      rst_n  = 1'b1;
      m_cc   = 3'b100;
      m_stat = 2'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ifc.icode = 4'h1; ifc.ifun = 4'h0;
      ifc.valA = '0; ifc.valB = '0; ifc.valC = '0;
      ifc.imem_error = 1'b0; ifc.instr_valid = 1'b1;
      #12;
      checks++;
      if (ifc.cc !== 3'b100) begin failures++; $display("FAIL reset_cc got=%b exp=100", ifc.cc); end
      checks++;
      if (ifc.stat !== 2'd0) begin failures++; $display("FAIL reset_stat got=%0d exp=0", ifc.stat); end
      @(negedge clk);
      rst_n  = 1'b1;
      m_cc   = 3'b100;
      m_stat = 2'd0;
   endtask

   task automatic test_add_zero();
      cycle(4'h6, 4'h0, 64'd5, -64'sd5, 64'd0, 1'b0, 1'b1);
      checks++;
      if (o_valE !== 64'd0) begin failures++; $display("FAIL add_zero_valE got=%h exp=0", o_valE); end
      checks++;
      if (o_cc !== 3'b100) begin failures++; $display("FAIL add_zero_cc got=%b exp=100", o_cc); end
   endtask

   task automatic test_sub_overflow();
      cycle(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1);
      checks++;
      if (o_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sub_ovf_valE got=%h exp=7fffffffffffffff", o_valE); end
      checks++;
      if (o_cc !== 3'b001) begin failures++; $display("FAIL sub_ovf_cc got=%b exp=001", o_cc); end
   endtask

   task automatic test_cond_after_overflow();
      cycle(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1);
      checks++;
      if (o_cc !== 3'b011) begin failures++; $display("FAIL add_ovf_cc got=%b exp=011", o_cc); end
      // SF=1, OF=1, ZF=0: le is (SF^OF)|ZF = 0, g is !(SF^OF)&!ZF = 1.
      cycle(4'h2, 4'h1, 64'h1234, 64'hDEAD, 64'd0, 1'b0, 1'b1);
      checks++;
      if (o_cnd !== 1'b0) begin failures++; $display("FAIL cmovle_cnd got=%b exp=0", o_cnd); end
      checks++;
      if (o_valE !== 64'h1234) begin failures++; $display("FAIL cmovle_valE got=%h exp=1234", o_valE); end
      cycle(4'h7, 4'h6, 64'd0, 64'd0, 64'h40, 1'b0, 1'b1);
      checks++;
      if (o_cnd !== 1'b1) begin failures++; $display("FAIL jg_cnd got=%b exp=1", o_cnd); end
   endtask

   task automatic test_stack();
      cycle(4'hA, 4'h0, 64'd7, 64'h100, 64'd0, 1'b0, 1'b1);
      checks++;
      if (o_valE !== 64'hF8) begin failures++; $display("FAIL push_valE got=%h exp=f8", o_valE); end
      cycle(4'hB, 4'h0, 64'd7, 64'hF8, 64'd0, 1'b0, 1'b1);
      checks++;
      if (o_valE !== 64'h100) begin failures++; $display("FAIL pop_valE got=%h exp=100", o_valE); end
      checks++;
      if (o_cc !== 3'b011) begin failures++; $display("FAIL stack_cc got=%b exp=011", o_cc); end
   endtask

   task automatic test_halt_freeze();
      cycle(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
      checks++;
      if (o_stat !== 2'd1) begin failures++; $display("FAIL halt_stat got=%0d exp=1", o_stat); end
      cycle(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 1'b0, 1'b1);
      checks++;
      if (o_valE !== 64'd2) begin failures++; $display("FAIL halt_valE got=%h exp=2", o_valE); end
      checks++;
      if (o_cc !== 3'b011) begin failures++; $display("FAIL halt_cc got=%b exp=011", o_cc); end
      checks++;
      if (o_stat !== 2'd1) begin failures++; $display("FAIL halt_stat_hold got=%0d exp=1", o_stat); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ifc.stat !== 2'd0) begin failures++; $display("FAIL midreset_stat got=%0d exp=0", ifc.stat); end
      checks++;
      if (ifc.cc !== 3'b100) begin failures++; $display("FAIL midreset_cc got=%b exp=100", ifc.cc); end
      checks++;
      if (ifc.valE !== 64'd2) begin failures++; $display("FAIL midreset_valE got=%h exp=2", ifc.valE); end
      @(negedge clk);
      rst_n  = 1'b1;
      m_cc   = 3'b100;
      m_stat = 2'd0;
   endtask

   task automatic test_error_priority();
      cycle(4'h6, 4'h0, 64'd3, 64'd9, 64'd0, 1'b1, 1'b0);
      checks++;
      if (o_stat !== 2'd2) begin failures++; $display("FAIL adr_stat got=%0d exp=2", o_stat); end
      checks++;
      if (o_cc !== 3'b100) begin failures++; $display("FAIL adr_cc got=%b exp=100", o_cc); end
      do_reset();
      cycle(4'h6, 4'h7, 64'd3, 64'd9, 64'd0, 1'b0, 1'b1);
      checks++;
      if (o_stat !== 2'd3) begin failures++; $display("FAIL ins_stat got=%0d exp=3", o_stat); end
      checks++;
      if (o_valE !== 64'd0) begin failures++; $display("FAIL ins_valE got=%h exp=0", o_valE); end
      checks++;
      if (o_cc !== 3'b100) begin failures++; $display("FAIL ins_cc got=%b exp=100", o_cc); end
      do_reset();
   endtask

   function automatic logic [63:0] rand_operand();
      logic [63:0] edges [6];
      edges = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
      return {$urandom, $urandom};
   endfunction

   task automatic test_random();
      logic [3:0] ic, fn;
      logic       err, vld;
      for (int i = 0; i < 400; i++) begin
         ic  = ($urandom_range(0, 30) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
         if ($urandom_range(0, 20) == 0) fn = 4'($urandom_range(0, 15));
         else if (ic == 4'h6)           fn = 4'($urandom_range(0, 3));
         else                           fn = 4'($urandom_range(0, 6));
         if (ic == 4'h6 && $urandom_range(0, 1) == 0) fn = 4'($urandom_range(0, 1));
         err = ($urandom_range(0, 40) == 0);
         vld = ($urandom_range(0, 40) != 0);
         cycle(ic, fn, rand_operand(), rand_operand(), rand_operand(), err, vld);
         checks++;
         if (o_valE !== e_valE) begin failures++; $display("FAIL rand_valE i=%0d ic=%h fn=%h got=%h exp=%h", i, ic, fn, o_valE, e_valE); end
         checks++;
         if (o_cnd !== e_cnd) begin failures++; $display("FAIL rand_cnd i=%0d ic=%h fn=%h got=%b exp=%b", i, ic, fn, o_cnd, e_cnd); end
         checks++;
         if (o_cc !== m_cc) begin failures++; $display("FAIL rand_cc i=%0d got=%b exp=%b", i, o_cc, m_cc); end
         checks++;
         if (o_stat !== m_stat) begin failures++; $display("FAIL rand_stat i=%0d got=%0d exp=%0d", i, o_stat, m_stat); end
         if (m_stat != 2'd0 && $urandom_range(0, 3) == 0) do_reset();
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_add_zero();
      test_sub_overflow();
      test_cond_after_overflow();
      test_stack();
      test_halt_freeze();
      test_error_priority();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
